// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction front end.
// Direction encoding, reset direction, reversal check and one-hot decode.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  // True when b points straight back along a (a 180 degree turn).
  function automatic logic is_reverse(dir_t a, dir_t b);
    logic rev;
    case (a)
      DIR_UP:    rev = (b == DIR_DOWN);
      DIR_DOWN:  rev = (b == DIR_UP);
      DIR_RIGHT: rev = (b == DIR_LEFT);
      default:   rev = (b == DIR_RIGHT);
    endcase
    return rev;
  endfunction

  // One-hot output vector ordered {up, down, right, left}.
  function automatic logic [3:0] dir_onehot(dir_t d);
    logic [3:0] oh;
    case (d)
      DIR_UP:    oh = 4'b1000;
      DIR_DOWN:  oh = 4'b0100;
      DIR_RIGHT: oh = 4'b0010;
      default:   oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One board key: 2-flop synchronizer, stable-level debouncer and
// single-cycle press pulse (released -> pressed only).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic resetN,
  input  logic key_n,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             prev_q, prev_d;
  logic             pulse_q, pulse_d;

  // Next-state: synchronize, count disagreement cycles, detect the rise.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sync_d   = {sync_q[0], ~key_n};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    prev_d  = stable_q;
    pulse_d = stable_q & ~prev_q;
  end

  // State registers; everything returns to the released level on reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/direction_ctrl.sv
// Snake direction controller: four debounced keys -> buffered request ->
// committed on step_tick with 180-degree reversal rejection.
// Build option DIR_QUEUE_EN: 2-entry request FIFO instead of the
// single overwrite entry.
module direction_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic resetN,
  input  logic keyN_up,
  input  logic keyN_down,
  input  logic keyN_right,
  input  logic keyN_left,
  input  logic step_tick,
  input  logic endgame,
  output logic up,
  output logic down,
  output logic right,
  output logic left,
  output logic key_event
);

  logic [3:0] press;  // {up, down, right, left}
  logic [3:0] keys_n;
  assign keys_n = {keyN_up, keyN_down, keyN_right, keyN_left};

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk        (clk),
      .resetN     (resetN),
      .key_n      (keys_n[g]),
      .press_pulse(press[g])
    );
  end

  assign key_event = |press;

  logic press_valid;
  dir_t press_dir;

  // Fixed priority among simultaneous press events: up > down > right > left.
  always_comb begin
    press_valid = |press;
    press_dir   = DIR_LEFT;
    if (press[3])      press_dir = DIR_UP;
    else if (press[2]) press_dir = DIR_DOWN;
    else if (press[1]) press_dir = DIR_RIGHT;
  end

  dir_t       dir_q, dir_d;
  logic [3:0] onehot_q, onehot_d;
  logic       head_valid;
  dir_t       head_dir;

`ifdef DIR_QUEUE_EN
  dir_t       fifo_q [2];
  dir_t       fifo_d [2];
  logic [1:0] count_q, count_d;
  dir_t       tail_dir;

  assign head_valid = (count_q != 2'd0);
  assign head_dir   = fifo_q[0];

  // FIFO update: pop on tick first, then enqueue the new press.
  always_comb begin
    fifo_d   = fifo_q;
    count_d  = count_q;
    tail_dir = fifo_q[0];
    if (endgame) begin
      count_d = 2'd0;
    end else begin
      if (step_tick && head_valid) begin
        fifo_d[0] = fifo_q[1];
        count_d   = count_q - 2'd1;
      end
      tail_dir = (count_d == 2'd2) ? fifo_d[1] : fifo_d[0];
      if (press_valid) begin
        if (count_d == 2'd0) begin
          fifo_d[0] = press_dir;
          count_d   = 2'd1;
        end else if (tail_dir != press_dir) begin
          // Append when one entry is held, overwrite the tail when full.
          fifo_d[1] = press_dir;
          count_d   = 2'd2;
        end
      end
    end
  end

  // FIFO storage and occupancy.
  // NOTE: the two FIFO slots are reset too; they are tiny and this keeps X out of the head compare.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fifo_q[0] <= DIR_RESET;
      fifo_q[1] <= DIR_RESET;
      count_q   <= 2'd0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
    end
  end
`else
  logic pend_valid_q, pend_valid_d;
  dir_t pend_dir_q, pend_dir_d;

  assign head_valid = pend_valid_q;
  assign head_dir   = pend_dir_q;

  // Single pending entry: tick consumes it, a press (same cycle or not) rewrites it.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    if (endgame) begin
      pend_valid_d = 1'b0;
    end else begin
      if (step_tick) pend_valid_d = 1'b0;
      if (press_valid) begin
        pend_dir_d   = press_dir;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Pending entry register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_RESET;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
    end
  end
`endif

  // Commit the head request on a tick unless it is a reversal or frozen by endgame.
  always_comb begin
    dir_d = dir_q;
    if (!endgame && step_tick && head_valid && !is_reverse(dir_q, head_dir)) begin
      dir_d = head_dir;
    end
    onehot_d = dir_onehot(dir_d);
  end

  // Current direction and its registered one-hot decode.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dir_q    <= DIR_RESET;
      onehot_q <= dir_onehot(DIR_RESET);
    end else begin
      dir_q    <= dir_d;
      onehot_q <= onehot_d;
    end
  end

  assign {up, down, right, left} = onehot_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed self-checking bench for direction_ctrl with DEBOUNCE_CYCLES=4.
module tb_direction_ctrl;

  localparam logic [3:0] EXP_UP    = 4'b1000;
  localparam logic [3:0] EXP_DOWN  = 4'b0100;
  localparam logic [3:0] EXP_RIGHT = 4'b0010;
  localparam logic [3:0] EXP_LEFT  = 4'b0001;
  localparam int K_UP = 3, K_DOWN = 2, K_RIGHT = 1, K_LEFT = 0;
  localparam int PRESS_LAT = 7;  // 3 + DEBOUNCE_CYCLES

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] keys_n = 4'hF;  // {up, down, right, left}
  logic       step_tick = 1'b0;
  logic       endgame = 1'b0;
  logic       up, down, right, left, key_event;

  int errors = 0;
  int checks = 0;

  direction_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .keyN_up   (keys_n[3]),
    .keyN_down (keys_n[2]),
    .keyN_right(keys_n[1]),
    .keyN_left (keys_n[0]),
    .step_tick (step_tick),
    .endgame   (endgame),
    .up        (up),
    .down      (down),
    .right     (right),
    .left      (left),
    .key_event (key_event)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dir_bits();
    return {up, down, right, left};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetN = 1'b0; keys_n = 4'hF; step_tick = 1'b0; endgame = 1'b0;
    repeat (2) step();
    resetN = 1'b1;
    step();
  endtask

  task automatic do_tick();
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
  endtask

  // Press key k, report cycles until key_event (-1 on timeout), release and settle.
  task automatic press_key(input int k, output int lat);
    lat = -1;
    keys_n[k] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (key_event) begin lat = i; break; end
    end
    keys_n[k] = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_reset();
    logic seen = 1'b0;
    checks++;
    if (dir_bits() !== EXP_RIGHT || key_event !== 1'b0) begin
      errors++; $display("FAIL in_reset: dir=%b kev=%b expected dir=%b kev=0", dir_bits(), key_event, EXP_RIGHT);
    end
    apply_reset();
    for (int t = 0; t < 20; t++) begin
      do_tick();
      if (key_event) seen = 1'b1;
      step();
      if (key_event) seen = 1'b1;
      checks++;
      if (dir_bits() !== EXP_RIGHT) begin
        errors++; $display("FAIL idle_tick%0d: dir=%b expected %b", t, dir_bits(), EXP_RIGHT);
      end
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL idle_key_event: seen=%b expected 0", seen); end
  endtask

  task automatic test_press_commit();
    int lat = -1;
    apply_reset();
    keys_n[K_UP] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (key_event) begin lat = i; break; end
    end
    checks++;
    if (lat !== PRESS_LAT) begin errors++; $display("FAIL press_latency: got %0d expected %0d", lat, PRESS_LAT); end
    step();
    checks++;
    if (key_event !== 1'b0) begin errors++; $display("FAIL pulse_width: kev=%b expected 0", key_event); end
    repeat (10) step();
    checks++;
    if (dir_bits() !== EXP_RIGHT) begin errors++; $display("FAIL before_tick: dir=%b expected %b", dir_bits(), EXP_RIGHT); end
    do_tick();
    checks++;
    if (dir_bits() !== EXP_UP) begin errors++; $display("FAIL commit_up: dir=%b expected %b", dir_bits(), EXP_UP); end
    keys_n[K_UP] = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_bounce();
    logic seen = 1'b0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      keys_n[K_UP] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (key_event) seen = 1'b1;
    end
    keys_n[K_UP] = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (key_event) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL bounce_event: seen=%b expected 0", seen); end
    do_tick();
    checks++;
    if (dir_bits() !== EXP_RIGHT) begin errors++; $display("FAIL bounce_dir: dir=%b expected %b", dir_bits(), EXP_RIGHT); end
  endtask

  task automatic test_reverse();
    int lat;
    apply_reset();
    press_key(K_LEFT, lat);
    do_tick();
    checks++;
    if (dir_bits() !== EXP_RIGHT) begin errors++; $display("FAIL reverse_left: dir=%b expected %b", dir_bits(), EXP_RIGHT); end
    press_key(K_UP, lat);
    press_key(K_LEFT, lat);
    do_tick();
    checks++;
`ifdef DIR_QUEUE_EN
    if (dir_bits() !== EXP_UP) begin errors++; $display("FAIL queue_first: dir=%b expected %b", dir_bits(), EXP_UP); end
`else
    if (dir_bits() !== EXP_RIGHT) begin errors++; $display("FAIL overwrite_left: dir=%b expected %b", dir_bits(), EXP_RIGHT); end
`endif
    do_tick();
    checks++;
`ifdef DIR_QUEUE_EN
    if (dir_bits() !== EXP_LEFT) begin errors++; $display("FAIL queue_second: dir=%b expected %b", dir_bits(), EXP_LEFT); end
    apply_reset();
`else
    if (dir_bits() !== EXP_RIGHT) begin errors++; $display("FAIL pending_cleared: dir=%b expected %b", dir_bits(), EXP_RIGHT); end
`endif
    press_key(K_DOWN, lat);
    do_tick();
    checks++;
    if (dir_bits() !== EXP_DOWN) begin errors++; $display("FAIL legal_down: dir=%b expected %b", dir_bits(), EXP_DOWN); end
    press_key(K_UP, lat);
    do_tick();
    checks++;
    if (dir_bits() !== EXP_DOWN) begin errors++; $display("FAIL reverse_up: dir=%b expected %b", dir_bits(), EXP_DOWN); end
    press_key(K_DOWN, lat);
    do_tick();
    checks++;
    if (dir_bits() !== EXP_DOWN) begin errors++; $display("FAIL same_dir: dir=%b expected %b", dir_bits(), EXP_DOWN); end
  endtask

  task automatic test_simultaneous();
    int lat;
    apply_reset();
    keys_n[K_DOWN] = 1'b0;
    keys_n[K_LEFT] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (key_event) begin lat = i; break; end
    end
    keys_n = 4'hF;
    repeat (10) step();
    checks++;
    if (lat !== PRESS_LAT) begin errors++; $display("FAIL simul_latency: got %0d expected %0d", lat, PRESS_LAT); end
    do_tick();
    checks++;
    if (dir_bits() !== EXP_DOWN) begin errors++; $display("FAIL simul_priority: dir=%b expected %b", dir_bits(), EXP_DOWN); end
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_reset();
    press_key(K_DOWN, lat);       // old entry: DOWN
    keys_n[K_LEFT] = 1'b0;
    repeat (PRESS_LAT) step();
    checks++;
    if (key_event !== 1'b1) begin errors++; $display("FAIL coincident_event: kev=%b expected 1", key_event); end
    do_tick();                    // tick in the press-event cycle
    checks++;
    if (dir_bits() !== EXP_DOWN) begin errors++; $display("FAIL old_entry_first: dir=%b expected %b", dir_bits(), EXP_DOWN); end
    keys_n[K_LEFT] = 1'b1;
    repeat (10) step();
    checks++;
    if (dir_bits() !== EXP_DOWN) begin errors++; $display("FAIL new_not_committed: dir=%b expected %b", dir_bits(), EXP_DOWN); end
    do_tick();
    checks++;
    if (dir_bits() !== EXP_LEFT) begin errors++; $display("FAIL new_entry_next: dir=%b expected %b", dir_bits(), EXP_LEFT); end
  endtask

  task automatic test_endgame();
    int lat;
    apply_reset();
    press_key(K_UP, lat);
    endgame = 1'b1;
    step();
    do_tick();
    checks++;
    if (dir_bits() !== EXP_RIGHT) begin errors++; $display("FAIL endgame_hold: dir=%b expected %b", dir_bits(), EXP_RIGHT); end
    press_key(K_DOWN, lat);
    checks++;
    if (lat !== PRESS_LAT) begin errors++; $display("FAIL endgame_key_event: got %0d expected %0d", lat, PRESS_LAT); end
    endgame = 1'b0;
    step();
    do_tick();
    checks++;
    if (dir_bits() !== EXP_RIGHT) begin errors++; $display("FAIL endgame_cleared: dir=%b expected %b", dir_bits(), EXP_RIGHT); end
  endtask

  task automatic test_async_reset();
    int lat;
    logic seen = 1'b0;
    apply_reset();
    press_key(K_UP, lat);
    do_tick();
    press_key(K_LEFT, lat);       // pending LEFT, legal from UP
    keys_n[K_DOWN] = 1'b0;        // mid-debounce
    repeat (4) step();
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (dir_bits() !== EXP_RIGHT || key_event !== 1'b0) begin
      errors++; $display("FAIL async_reset: dir=%b kev=%b expected dir=%b kev=0", dir_bits(), key_event, EXP_RIGHT);
    end
    keys_n = 4'hF;
    step();
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (key_event) seen = 1'b1; end
    do_tick();
    checks++;
    if (dir_bits() !== EXP_RIGHT || seen !== 1'b0) begin
      errors++; $display("FAIL reset_cleared: dir=%b seen=%b expected dir=%b seen=0", dir_bits(), seen, EXP_RIGHT);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_press_commit();
    test_bounce();
    test_reverse();
    test_simultaneous();
    test_back_to_back();
    test_endgame();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
